wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back data formatting for the pipelined MIPS core.
- Captures memory-stage results and performs load byte/half extraction with sign/zero extension.
- Selects the write-back source and drives the GRF write port (RegWrite, WA, WD).
- Also exposes the same write for forwarding to earlier stages.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter (optional feature only).
- ZERO_GUARD, 1, when 1 a write to register 0 is suppressed at the output.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low; clears all state immediately.
- Stall  input  1  hold the WB register contents.
- Flush  input  1  load a bubble into the WB register.
- M_Valid  input  1  MEM stage holds a real instruction.
- M_RegWrite  input  1  instruction writes the GRF.
- M_WA  input  5  destination register.
- M_WBSel  input  2  write-back source: 00 ALU, 01 memory, 10 PC+8, 11 reserved (treated as ALU).
- M_LdType  input  3  load format: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; others treated as word.
- M_ByteOff  input  2  address bits [1:0] of the load.
- M_ALURes  input  32  ALU/MDU result.
- M_MemRD  input  32  raw word read from data memory.
- M_PC8  input  32  PC+8 for link instructions.
- RegWrite  output  1  GRF write enable.
- WA  output  5  GRF write address.
- WD  output  32  GRF write data.
- W_Valid  output  1  WB holds a real instruction.
- LdErr  output  1  the current WB load is misaligned.
- InstrCount  output  CNT_WIDTH  retired instruction count (only present with the optional feature).

Behaviour:
- Reset (Reset=0, asynchronous): all WB register fields clear to 0. RegWrite=0, WA=0, WD=0, W_Valid=0, LdErr=0, InstrCount=0. Reset asserted mid-operation discards the held instruction; no GRF write occurs.
- Register update priority on each rising edge: Flush > Stall > capture.
  - Flush=1: bubble loaded; all fields 0, Valid=0.
  - Stall=1 (Flush=0): all fields hold.
  - Otherwise: all M_* fields are captured.
- Latency: one cycle from M_* capture to the WB outputs. The GRF commits at the following edge. Outputs are combinational from the registered fields only; no M_* input reaches an output combinationally.
- Load extraction from the registered MemRD using ByteOff:
  - Byte: lane ByteOff (0 = bits [7:0] … 3 = bits [31:24]).
  - Half: ByteOff[1]=0 selects [15:0], ByteOff[1]=1 selects [31:16].
  - Signed types replicate the MSB of the selected lane; unsigned types zero-fill.
- Misalignment:
  - Word load with ByteOff≠00, or half load with ByteOff[0]=1, sets LdErr=1 while held.
  - Misalignment forces RegWrite=0 regardless of M_RegWrite.
  - LdErr is evaluated only when WBSel=01 and Valid=1.
- RegWrite = Valid & regRegWrite & ~LdErr & ~(ZERO_GUARD & WA==0).
- WD is always driven with the selected value, even when RegWrite=0.
- While Stall=1, RegWrite stays asserted for the held instruction. The GRF rewrites the same value each cycle, which is idempotent.
- W_Valid = registered Valid, unaffected by LdErr.

Optional Feature:
- Macro: WB_INSTR_CNT_EN.
- Defined:
  - InstrCount increments by 1 on each rising edge where W_Valid=1 and the register is not stalled, i.e. each instruction counts exactly once.
  - A misaligned load still counts.
  - Wraps from 2^CNT_WIDTH−1 to 0.
  - Cleared by reset.
- Undefined: the InstrCount port and the counter logic are absent.

Test Plan:
- Reset=0 mid-stream with a valid ALU write held → all outputs 0 immediately, before any clock edge; release, feed M_WA=5, ALURes=0x1234 → next cycle RegWrite=1, WA=5, WD=0x00001234.
- MemRD=0x80FF7F01, LdType=byte signed, ByteOff=2 → WD=0xFFFFFFFF; ByteOff=1, byte unsigned → WD=0x0000007F; half signed, ByteOff=2 → WD=0xFFFF80FF.
- Half load with ByteOff=1 → LdErr=1, RegWrite=0, W_Valid=1; word load with ByteOff=0 → LdErr=0, WD=0x80FF7F01.
- WBSel=10, PC8=0x00003008, WA=31 → WD=0x00003008, RegWrite=1; WA=0 with ZERO_GUARD=1 → RegWrite=0.
- Stall=1 for 3 cycles after capture → outputs constant; Stall=1 with Flush=1 → bubble (W_Valid=0, RegWrite=0).
- With WB_INSTR_CNT_EN: 4 valid instructions, 1 bubble, 2 stall cycles → InstrCount=4; with CNT_WIDTH=2, 5 instructions → InstrCount=1.

Source files
------------

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load extraction and write-back select; one cycle of latency, Stall holds and Flush inserts a bubble.
// Optional retired-instruction counter is enabled by defining WB_INSTR_CNT_EN.
module wb_stage #(
  parameter int CNT_WIDTH  = 32,
  parameter int ZERO_GUARD = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        M_Valid,
  input  logic        M_RegWrite,
  input  logic [4:0]  M_WA,
  input  logic [1:0]  M_WBSel,
  input  logic [2:0]  M_LdType,
  input  logic [1:0]  M_ByteOff,
  input  logic [31:0] M_ALURes,
  input  logic [31:0] M_MemRD,
  input  logic [31:0] M_PC8,
  output logic        RegWrite,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic        W_Valid,
  output logic        LdErr
`ifdef WB_INSTR_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] InstrCount
`endif
);

  logic        valid_q, valid_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  wa_q, wa_d;
  logic [1:0]  wbsel_q, wbsel_d;
  logic [2:0]  ldtype_q, ldtype_d;
  logic [1:0]  byteoff_q, byteoff_d;
  logic [31:0] alures_q, alures_d;
  logic [31:0] memrd_q, memrd_d;
  logic [31:0] pc8_q, pc8_d;

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    wa_d       = wa_q;
    wbsel_d    = wbsel_q;
    ldtype_d   = ldtype_q;
    byteoff_d  = byteoff_q;
    alures_d   = alures_q;
    memrd_d    = memrd_q;
    pc8_d      = pc8_q;
    if (Flush) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      wa_d       = 5'd0;
      wbsel_d    = 2'd0;
      ldtype_d   = 3'd0;
      byteoff_d  = 2'd0;
      alures_d   = 32'd0;
      memrd_d    = 32'd0;
      pc8_d      = 32'd0;
    end else if (!Stall) begin
      valid_d    = M_Valid;
      regwrite_d = M_RegWrite;
      wa_d       = M_WA;
      wbsel_d    = M_WBSel;
      ldtype_d   = M_LdType;
      byteoff_d  = M_ByteOff;
      alures_d   = M_ALURes;
      memrd_d    = M_MemRD;
      pc8_d      = M_PC8;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wa_q       <= 5'd0;
      wbsel_q    <= 2'd0;
      ldtype_q   <= 3'd0;
      byteoff_q  <= 2'd0;
      alures_q   <= 32'd0;
      memrd_q    <= 32'd0;
      pc8_q      <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wbsel_q    <= wbsel_d;
      ldtype_q   <= ldtype_d;
      byteoff_q  <= byteoff_d;
      alures_q   <= alures_d;
      memrd_q    <= memrd_d;
      pc8_q      <= pc8_d;
    end
  end

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic        is_half, is_byte, misalign, zero_dst;

  always_comb begin
    case (byteoff_q)
      2'd0:    byte_lane = memrd_q[7:0];
      2'd1:    byte_lane = memrd_q[15:8];
      2'd2:    byte_lane = memrd_q[23:16];
      default: byte_lane = memrd_q[31:24];
    endcase
    half_lane = byteoff_q[1] ? memrd_q[31:16] : memrd_q[15:0];
    is_byte   = (ldtype_q == 3'b001) || (ldtype_q == 3'b010);
    is_half   = (ldtype_q == 3'b011) || (ldtype_q == 3'b100);
    case (ldtype_q)
      3'b001:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b010:  load_data = {24'd0, byte_lane};
      3'b011:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_data = {16'd0, half_lane};
      default: load_data = memrd_q;
    endcase
    // Any type that is neither byte nor half behaves as a word load.
    misalign = is_half ? byteoff_q[0] : (!is_byte && (byteoff_q != 2'd0));
  end

  always_comb begin
    LdErr    = valid_q && (wbsel_q == 2'b01) && misalign;
    zero_dst = (ZERO_GUARD != 0) && (wa_q == 5'd0);
    RegWrite = valid_q && regwrite_q && !LdErr && !zero_dst;
    WA       = wa_q;
    W_Valid  = valid_q;
    case (wbsel_q)
      2'b01:   WD = load_data;
      2'b10:   WD = pc8_q;
      default: WD = alures_q;
    endcase
  end

`ifdef WB_INSTR_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // An instruction retires when it leaves WB: any edge not holding it.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && (Flush || !Stall))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign InstrCount = cnt_q;
`else
  logic unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a transaction-level reference model.
module tb_wb_stage;

  logic        Clock = 1'b0;
  logic        Reset, Stall, Flush, M_Valid, M_RegWrite;
  logic [4:0]  M_WA;
  logic [1:0]  M_WBSel, M_ByteOff;
  logic [2:0]  M_LdType;
  logic [31:0] M_ALURes, M_MemRD, M_PC8;
  logic        RegWrite, W_Valid, LdErr;
  logic [4:0]  WA;
  logic [31:0] WD;

  int errs = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

`ifdef WB_INSTR_CNT_EN
  logic [31:0] InstrCount;
  logic [1:0]  InstrCount2;
  logic        rw2, v2, le2;
  logic [4:0]  wa2;
  logic [31:0] wd2;
  wb_stage #(.CNT_WIDTH(2), .ZERO_GUARD(1)) dut2 (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .M_Valid(M_Valid), .M_RegWrite(M_RegWrite), .M_WA(M_WA), .M_WBSel(M_WBSel),
    .M_LdType(M_LdType), .M_ByteOff(M_ByteOff), .M_ALURes(M_ALURes),
    .M_MemRD(M_MemRD), .M_PC8(M_PC8), .RegWrite(rw2), .WA(wa2), .WD(wd2),
    .W_Valid(v2), .LdErr(le2), .InstrCount(InstrCount2));
`endif

  wb_stage #(.CNT_WIDTH(32), .ZERO_GUARD(1)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .M_Valid(M_Valid), .M_RegWrite(M_RegWrite), .M_WA(M_WA), .M_WBSel(M_WBSel),
    .M_LdType(M_LdType), .M_ByteOff(M_ByteOff), .M_ALURes(M_ALURes),
    .M_MemRD(M_MemRD), .M_PC8(M_PC8), .RegWrite(RegWrite), .WA(WA), .WD(WD),
    .W_Valid(W_Valid), .LdErr(LdErr)
`ifdef WB_INSTR_CNT_EN
    , .InstrCount(InstrCount)
`endif
  );

  typedef struct packed {
    bit        v, rw;
    bit [4:0]  wa;
    bit [1:0]  sel;
    bit [2:0]  lt;
    bit [1:0]  off;
    bit [31:0] alu, rd, pc8;
  } rec_t;

  rec_t      mdl;
  bit [31:0] cnt;
  bit [1:0]  cnt2;

  // Expected {RegWrite, WA, WD, W_Valid, LdErr} for the instruction held in WB.
  function automatic logic [39:0] exp_out();
    bit [31:0] wd, lane;
    bit err, wr;
    int kind;  // 0 word, 1 byte, 2 half
    kind = (mdl.lt == 1 || mdl.lt == 2) ? 1 : (mdl.lt == 3 || mdl.lt == 4) ? 2 : 0;
    if (kind == 1) begin
      lane = (mdl.rd >> (8 * mdl.off)) & 32'hFF;
      wd = (mdl.lt == 1 && lane >= 128) ? lane - 32'd256 : lane;
    end else if (kind == 2) begin
      lane = (mdl.rd >> (mdl.off >= 2 ? 16 : 0)) & 32'hFFFF;
      wd = (mdl.lt == 3 && lane >= 32768) ? lane - 32'd65536 : lane;
    end else begin
      wd = mdl.rd;
    end
    err = mdl.v && mdl.sel == 1 &&
          ((kind == 0 && mdl.off != 0) || (kind == 2 && mdl.off % 2 == 1));
    if (mdl.sel == 2) wd = mdl.pc8;
    else if (mdl.sel != 1) wd = mdl.alu;
    wr = mdl.v && mdl.rw && !err && mdl.wa != 0;
    return {wr, mdl.wa, wd, mdl.v, err};
  endfunction

  task automatic step();
    @(posedge Clock);
    if (mdl.v && !(Stall && !Flush)) begin
      cnt  = cnt + 1;
      cnt2 = cnt2 + 1;
    end
    if (Flush) mdl = '0;
    else if (!Stall)
      mdl = '{M_Valid, M_RegWrite, M_WA, M_WBSel, M_LdType, M_ByteOff, M_ALURes, M_MemRD, M_PC8};
    #1;
  endtask

  task automatic put(input bit v, input bit rw, input bit [4:0] wa, input bit [1:0] sel,
                     input bit [2:0] lt, input bit [1:0] off, input bit [31:0] alu,
                     input bit [31:0] rd, input bit [31:0] pc8);
    M_Valid = v; M_RegWrite = rw; M_WA = wa; M_WBSel = sel; M_LdType = lt;
    M_ByteOff = off; M_ALURes = alu; M_MemRD = rd; M_PC8 = pc8;
  endtask

  task automatic test_reset();
    Stall = 0; Flush = 0;
    put(1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'hCAFE0001, 32'd0, 32'd0);
    step();
    if ({RegWrite, WA, WD} !== {1'b1, 5'd9, 32'hCAFE0001}) begin
      errs++; $display("FAIL pre_reset got=%h exp=%h", {RegWrite, WA, WD}, {1'b1, 5'd9, 32'hCAFE0001});
    end
    checks++;
    #2 Reset = 0;
    mdl = '0; cnt = 0; cnt2 = 0;
    #1;
    if ({RegWrite, WA, WD, W_Valid, LdErr} !== 40'd0) begin
      errs++; $display("FAIL async_reset got=%h exp=0", {RegWrite, WA, WD, W_Valid, LdErr});
    end
    checks++;
    @(posedge Clock); #1;
    Reset = 1;
    put(1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234, 32'd0, 32'd0);
    step();
    if ({RegWrite, WA, WD} !== {1'b1, 5'd5, 32'h00001234}) begin
      errs++; $display("FAIL post_reset got=%h exp=%h", {RegWrite, WA, WD}, {1'b1, 5'd5, 32'h00001234});
    end
    checks++;
  endtask

  task automatic test_loads();
    bit [2:0]  lt[6]  = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0};
    bit [1:0]  off[6] = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3};
    bit [33:0] want[6] = '{{2'b10, 32'hFFFFFFFF}, {2'b10, 32'h0000007F}, {2'b10, 32'hFFFF80FF},
                           {2'b01, 32'h0}, {2'b10, 32'h80FF7F01}, {2'b01, 32'h0}};
    Stall = 0; Flush = 0;
    for (int i = 0; i < 6; i++) begin
      put(1, 1, 5'd3, 2'd1, lt[i], off[i], 32'h0, 32'h80FF7F01, 32'h0);
      step();
      // {RegWrite, LdErr} with WD only meaningful when no error.
      if ({RegWrite, LdErr} !== want[i][33:32] || W_Valid !== 1'b1 ||
          (!want[i][32] && WD !== want[i][31:0])) begin
        errs++; $display("FAIL load_%0d got=%b%b%b/%h exp=%b1/%h", i, RegWrite, LdErr, W_Valid, WD,
                         want[i][33:32], want[i][31:0]);
      end
      checks++;
      if ({RegWrite, WA, WD, W_Valid, LdErr} !== exp_out()) begin
        errs++; $display("FAIL load_model_%0d got=%h exp=%h", i, {RegWrite, WA, WD, W_Valid, LdErr}, exp_out());
      end
      checks++;
    end
  endtask

  task automatic test_link_zero();
    put(1, 1, 5'd31, 2'd2, 3'd0, 2'd3, 32'h55, 32'h0, 32'h00003008);
    step();
    if ({RegWrite, WD, LdErr} !== {1'b1, 32'h00003008, 1'b0}) begin
      errs++; $display("FAIL link got=%b/%h exp=1/00003008", RegWrite, WD);
    end
    checks++;
    put(1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h77, 32'h0, 32'h0);
    step();
    if ({RegWrite, WD, W_Valid} !== {1'b0, 32'h77, 1'b1}) begin
      errs++; $display("FAIL zero_guard got=%b/%h/%b exp=0/00000077/1", RegWrite, WD, W_Valid);
    end
    checks++;
  endtask

  task automatic test_stall_flush();
    logic [39:0] held;
    put(1, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'hABCD0123, 32'h0, 32'h0);
    step();
    held = exp_out();
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      put(1, 1, 5'($urandom), 2'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom);
      step();
      if ({RegWrite, WA, WD, W_Valid, LdErr} !== held) begin
        errs++; $display("FAIL stall_%0d got=%h exp=%h", i, {RegWrite, WA, WD, W_Valid, LdErr}, held);
      end
      checks++;
    end
    Flush = 1;
    step();
    if ({W_Valid, RegWrite} !== 2'b00) begin
      errs++; $display("FAIL stall_flush got=%b%b exp=00", W_Valid, RegWrite);
    end
    checks++;
    Stall = 0; Flush = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Stall = ($urandom_range(0, 4) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      put($urandom_range(0, 5) != 0, $urandom_range(0, 4) != 0,
          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 2'($urandom), 3'($urandom),
          2'($urandom), $urandom, $urandom, $urandom);
      step();
      if ({RegWrite, WA, WD, W_Valid, LdErr} !== exp_out()) begin
        errs++; $display("FAIL random_%0d got=%h exp=%h", i, {RegWrite, WA, WD, W_Valid, LdErr}, exp_out());
      end
      checks++;
`ifdef WB_INSTR_CNT_EN
      if (InstrCount !== cnt || InstrCount2 !== cnt2) begin
        errs++; $display("FAIL random_cnt_%0d got=%0d/%0d exp=%0d/%0d", i, InstrCount, InstrCount2, cnt, cnt2);
      end
      checks++;
`endif
    end
    Stall = 0; Flush = 0;
  endtask

`ifdef WB_INSTR_CNT_EN
  task automatic test_counter();
    @(negedge Clock);
    Reset = 0; mdl = '0; cnt = 0; cnt2 = 0;
    @(posedge Clock); #1;
    Reset = 1;
    if (InstrCount !== 32'd0 || InstrCount2 !== 2'd0) begin
      errs++; $display("FAIL cnt_reset got=%0d/%0d exp=0/0", InstrCount, InstrCount2);
    end
    checks++;
    Stall = 0; Flush = 0;
    for (int i = 0; i < 4; i++) begin
      put(1, 1, 5'(i + 1), 2'd1, 3'd0, 2'd1, 32'h0, 32'h0, 32'h0);  // misaligned still counts
      step();
    end
    put(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    step();
    Stall = 1;
    step(); step();
    Stall = 0;
    if (InstrCount !== 32'd4 || InstrCount2 !== 2'd0) begin
      errs++; $display("FAIL cnt_four got=%0d/%0d exp=4/0", InstrCount, InstrCount2);
    end
    checks++;
    put(1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h1, 32'h0, 32'h0);
    step();
    put(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    step();
    if (InstrCount !== 32'd5 || InstrCount2 !== 2'd1) begin
      errs++; $display("FAIL cnt_wrap got=%0d/%0d exp=5/1", InstrCount, InstrCount2);
    end
    checks++;
  endtask
`endif

  initial begin
    Reset = 0; Stall = 0; Flush = 0;
    put(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    mdl = '0; cnt = 0; cnt2 = 0;
    #1;
    if ({RegWrite, WA, WD, W_Valid, LdErr} !== 40'd0) begin
      errs++; $display("FAIL initial_reset got=%h exp=0", {RegWrite, WA, WD, W_Valid, LdErr});
    end
    checks++;
    @(posedge Clock); #1;
    Reset = 1;
    test_reset();
    test_loads();
    test_link_zero();
    test_stall_flush();
    test_random();
`ifdef WB_INSTR_CNT_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
